alpu_fpga_driver: RTL and testbench

//  Board-side operand-entry front end for the ALPU. It synchronises and debounces the board

---
 rtl/alpu_fpga_pkg.sv | 35 +++
 rtl/input_debounce.sv | 40 ++++
 rtl/alpu_fpga_driver.sv | 156 +++++++++++++++
 tb/tb_alpu_fpga_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alpu_fpga_pkg.sv
// rtl/alpu_fpga_pkg.sv - shared state type, button indices and step codes for the ALPU board driver
package alpu_fpga_pkg;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ENTER_OP,
    ISSUE,
    WAIT,
    SHOW
  } drv_state_t;

  localparam int BTN_CONFIRM = 0;
  localparam int BTN_CIN     = 1;
  localparam int BTN_REISSUE = 2;
  localparam int BTN_ABORT   = 3;

  localparam logic [2:0] STEP_A  = 3'b001;
  localparam logic [2:0] STEP_B  = 3'b010;
  localparam logic [2:0] STEP_OP = 3'b100;

  function automatic logic is_entry(drv_state_t s);
    return (s == ENTER_A) || (s == ENTER_B) || (s == ENTER_OP);
  endfunction

  function automatic logic [2:0] step_code(drv_state_t s);
    case (s)
      ENTER_A:  return STEP_A;
      ENTER_B:  return STEP_B;
      ENTER_OP: return STEP_OP;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - 2-flop synchroniser, level debouncer and rising-edge pulse for one button
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt tracks consecutive cycles where the synced input disagrees with the accepted level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alpu_fpga_driver.sv
// rtl/alpu_fpga_driver.sv - board-side operand entry, issue and result display for an external ALPU
module alpu_fpga_driver
  import alpu_fpga_pkg::*;
#(
  parameter int REG_WIDTH       = 4,
  parameter int INSTR_WIDTH     = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RESULT_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3:0]             sw,
  input  logic [3:0]             btn,
  output logic [3:0]             led,
  output logic [2:0]             led6,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [REG_WIDTH-1:0]   a_o,
  output logic [REG_WIDTH-1:0]   b_o,
  output logic                   cin_o,
  output logic                   issue_o,
  input  logic [REG_WIDTH-1:0]   out_i,
  input  logic                   cout_i
);

  localparam int WCW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((RESULT_LATENCY > 0) ? RESULT_LATENCY - 1 : 0);

  logic [3:0] sw_m, sw_s;
  logic [3:0] ev;

  drv_state_t             state, state_d;
  logic [REG_WIDTH-1:0]   a_d, b_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   cin_d;
  logic [3:0]             res_q, res_d;
  logic                   cout_q, cout_d;
  logic [WCW-1:0]         wcnt, wcnt_d;
  logic [3:0]             led_d;
  logic [2:0]             led6_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_m <= 4'h0;
      sw_s <= 4'h0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_btn
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn[g]),
      .rise    (ev[g])
    );
  end

  wire ev_abort   = ev[BTN_ABORT];
  wire ev_confirm = ev[BTN_CONFIRM];
  wire ev_reissue = ev[BTN_REISSUE];
  wire ev_cin     = ev[BTN_CIN];

  assign issue_o = (state == ISSUE);

  always_comb begin
    state_d = state;
    a_d     = a_o;
    b_d     = b_o;
    instr_d = instr_o;
    cin_d   = cin_o;
    res_d   = res_q;
    cout_d  = cout_q;
    wcnt_d  = wcnt;
    led_d   = 4'h0;
    led6_d  = 3'b000;

    case (state)
      ENTER_A:  if (ev_confirm) begin a_d = REG_WIDTH'(sw_s); state_d = ENTER_B; end
      ENTER_B:  if (ev_confirm) begin b_d = REG_WIDTH'(sw_s); state_d = ENTER_OP; end
      ENTER_OP: if (ev_confirm) begin instr_d = INSTR_WIDTH'(sw_s); state_d = ISSUE; end
      ISSUE: begin
        wcnt_d = '0;
        if (RESULT_LATENCY == 0) begin
          res_d   = out_i[3:0];
          cout_d  = cout_i;
          state_d = SHOW;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == WAIT_LAST) begin
          res_d   = out_i[3:0];
          cout_d  = cout_i;
          state_d = SHOW;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end
      SHOW: begin
        if (ev_confirm)      state_d = ENTER_A;
        else if (ev_reissue) state_d = ISSUE;
      end
      default: state_d = ENTER_A;
    endcase

    // toggle-cin is the lowest priority event and is lost if anything else fires
    if (ev_cin && !ev_confirm && !ev_reissue && !ev_abort && is_entry(state))
      cin_d = ~cin_o;

    if (ev_abort) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      instr_d = '0;
      cin_d   = 1'b0;
    end

    if (is_entry(state_d)) begin
      led_d  = sw_s;
      led6_d = step_code(state_d);
    end else if (state_d == SHOW) begin
      led_d  = res_d;
      led6_d = {2'b00, cout_d};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ENTER_A;
      a_o     <= '0;
      b_o     <= '0;
      instr_o <= '0;
      cin_o   <= 1'b0;
      res_q   <= 4'h0;
      cout_q  <= 1'b0;
      wcnt    <= '0;
      led     <= 4'h0;
      led6    <= 3'b000;
    end else begin
      state   <= state_d;
      a_o     <= a_d;
      b_o     <= b_d;
      instr_o <= instr_d;
      cin_o   <= cin_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      wcnt    <= wcnt_d;
      led     <= led_d;
      led6    <= led6_d;
    end
  end

endmodule

// File: tb/tb_alpu_fpga_driver.sv
// tb/tb_alpu_fpga_driver.sv - directed self-checking bench for alpu_fpga_driver with an adder ALPU model
module tb_alpu_fpga_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [3:0] btn = 4'h0;
  logic [3:0] led;
  logic [2:0] led6;
  logic [3:0] instr_o, a_o, b_o;
  logic       cin_o, issue_o;
  logic [3:0] out_i = 4'h0;
  logic       cout_i = 1'b0;
  logic       model_mode = 1'b0;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;

  alpu_fpga_driver #(
    .REG_WIDTH(4), .INSTR_WIDTH(4), .DEBOUNCE_CYCLES(4), .RESULT_LATENCY(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .btn(btn), .led(led), .led6(led6),
    .instr_o(instr_o), .a_o(a_o), .b_o(b_o), .cin_o(cin_o), .issue_o(issue_o),
    .out_i(out_i), .cout_i(cout_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (issue_o) {cout_i, out_i} <= model_mode ? 5'd2 : ({1'b0, a_o} + {1'b0, b_o} + {4'b0, cin_o});

  always @(negedge clk)
    if (issue_o) issue_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int b);
    @(negedge clk);
    btn[b] = 1'b1;
    repeat (12) @(negedge clk);
    btn[b] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_issue(input int b, output logic found, output logic [3:0] led_s,
                             output logic [2:0] led6_s);
    found = 1'b0;
    led_s = 4'hx;
    led6_s = 3'bx;
    @(negedge clk);
    btn[b] = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (issue_o) found = 1'b1;
    end
    if (found) begin
      repeat (2) @(negedge clk);
      led_s = led;
      led6_s = led6;
    end
    btn[b] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  logic       found;
  logic [3:0] led_s;
  logic [2:0] led6_s;
  int         n0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {led, led6, instr_o, a_o, b_o, cin_o, issue_o}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release_led6", led6, 3'b001);

    // 1: 5 + 3 with op 4
    sw = 4'h5; press(0);
    sw = 4'h3; press(0);
    sw = 4'h4; n0 = issue_cnt;
    press_issue(0, found, led_s, led6_s);
    check("t1_issue_seen", found, 1);
    check("t1_issue_count", issue_cnt - n0, 1);
    check("t1_operands", {a_o, b_o, instr_o}, 12'h534);
    check("t1_led", led_s, 4'h8);
    check("t1_led6", led6_s, 3'b000);

    // 2: F + 1 + cin
    press(0);
    check("t2_back_to_a", led6, 3'b001);
    sw = 4'hF; press(0);
    sw = 4'h1; press(0);
    press(1);
    check("t2_cin", cin_o, 1);
    sw = 4'h4;
    press_issue(0, found, led_s, led6_s);
    check("t2_issue_seen", found, 1);
    check("t2_led", led_s, 4'h1);
    check("t2_led6", led6_s, 3'b001);

    // 3: glitches on confirm must be rejected
    press(0);
    for (int r = 0; r < 3; r++)
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        btn[0] = 1'b1;
        repeat (k) @(negedge clk);
        btn[0] = 1'b0;
        repeat (3) @(negedge clk);
      end
    repeat (10) @(negedge clk);
    check("t3_led6", led6, 3'b001);
    check("t3_a_kept", a_o, 4'hF);

    // 4: abort and confirm together in ENTER_B
    sw = 4'h7; press(0);
    check("t4_in_b", led6, 3'b010);
    check("t4_a", a_o, 4'h7);
    @(negedge clk);
    btn = 4'b1001;
    repeat (12) @(negedge clk);
    btn = 4'b0000;
    repeat (12) @(negedge clk);
    check("t4_led6", led6, 3'b001);
    check("t4_cleared", {a_o, b_o, instr_o, cin_o}, 0);

    // 5: async reset in WAIT
    sw = 4'h2; press(0);
    sw = 4'h6; press(0);
    sw = 4'h1;
    found = 1'b0;
    @(negedge clk);
    btn[0] = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (issue_o) found = 1'b1;
    end
    check("t5_issue_seen", found, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("t5_reset_outputs", {led, led6, instr_o, a_o, b_o, cin_o, issue_o}, 0);
    btn = 4'h0;
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("t5_release_led6", led6, 3'b001);

    // 6: re-issue with a changed model result
    sw = 4'h3; press(0);
    sw = 4'h4; press(0);
    sw = 4'h0;
    press_issue(0, found, led_s, led6_s);
    check("t6_first_led", led_s, 4'h7);
    model_mode = 1'b1;
    n0 = issue_cnt;
    press_issue(2, found, led_s, led6_s);
    check("t6_reissue_seen", found, 1);
    check("t6_reissue_count", issue_cnt - n0, 1);
    check("t6_operands", {a_o, b_o, instr_o}, 12'h340);
    check("t6_led", led_s, 4'h2);
    check("t6_led6", led6_s, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
